// File: rtl/keypad_scan_if.sv
// Key-event channel between the keypad scanner and the calculator/stopwatch FSM.
// The scanner is the master; the consumer returns key_ready.
interface keypad_scan_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       key_release;
  logic       overrun;

  modport master (
    output key_code, key_valid, key_held, key_release, overrun,
    input  key_ready
  );

  modport slave (
    input  key_code, key_valid, key_held, key_release, overrun,
    output key_ready
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: strobes rows, samples synchronized columns, debounces over
// whole scans, rejects ghost patterns and emits press/release events.
module keypad_scan_ctrl #(
  parameter int ROW_DWELL = 12500,
  parameter int DEB_SCANS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic [3:0]    col_i,
  output logic [3:0]    row_o,
  keypad_scan_if.master kp
);

  localparam int DW_W = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam int SC_W = $clog2(DEB_SCANS + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(ROW_DWELL - 1);
  localparam logic [SC_W-1:0] SC_MAX     = SC_W'(DEB_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_NEXT, S_EVAL} state_t;
  typedef enum logic [1:0] {R_NONE, R_KEY, R_MULTI} res_t;

  // Matrix position (row*4 + col) to key code.
  function automatic logic [3:0] code_of(input logic [3:0] pos);
    case (pos)
      4'd0:    code_of = 4'd1;
      4'd1:    code_of = 4'd2;
      4'd2:    code_of = 4'd3;
      4'd3:    code_of = 4'd10;
      4'd4:    code_of = 4'd4;
      4'd5:    code_of = 4'd5;
      4'd6:    code_of = 4'd6;
      4'd7:    code_of = 4'd11;
      4'd8:    code_of = 4'd7;
      4'd9:    code_of = 4'd8;
      4'd10:   code_of = 4'd9;
      4'd11:   code_of = 4'd12;
      4'd12:   code_of = 4'd15;
      4'd13:   code_of = 4'd0;
      4'd14:   code_of = 4'd14;
      default: code_of = 4'd13;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [3:0][3:0] pat_q, pat_d;
  logic [3:0]      col_meta_q, col_s_q;
  res_t            cand_kind_q, cand_kind_d;
  logic [3:0]      cand_code_q, cand_code_d;
  logic [SC_W-1:0] stable_q, stable_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            key_release_q, key_release_d;
  logic            overrun_q, overrun_d;

  logic [15:0]     low_bits;
  logic [4:0]      n_low;
  res_t            res_kind;
  logic [3:0]      res_code;

  // Pattern bit r*4+c is low when column c read low while row r was strobed.
  always_comb begin
    low_bits = ~pat_q;
    n_low    = 5'd0;
    res_kind = R_NONE;
    res_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (low_bits[i]) begin
        n_low    = n_low + 5'd1;
        res_code = code_of(4'(i));
      end
    end
    if (n_low == 5'd1) begin
      res_kind = R_KEY;
    end else if (n_low > 5'd1) begin
      res_kind = R_MULTI;
      res_code = 4'd0;
    end else begin
      res_code = 4'd0;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    dwell_d       = dwell_q;
    pat_d         = pat_q;
    cand_kind_d   = cand_kind_q;
    cand_code_d   = cand_code_q;
    stable_d      = stable_q;
    key_code_d    = key_code_q;
    key_valid_d   = key_valid_q;
    key_held_d    = key_held_q;
    key_release_d = 1'b0;
    overrun_d     = overrun_q;

    if (key_valid_q && kp.key_ready) begin
      key_valid_d = 1'b0;
    end

    if (enable_i) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_DRIVE;
          idx_d   = 2'd0;
          dwell_d = '0;
        end
        S_DRIVE: begin
          if (dwell_q == DWELL_LAST) begin
            pat_d[idx_q] = col_s_q;
            dwell_d      = '0;
            state_d      = S_NEXT;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
        S_NEXT: begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = S_EVAL;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_DRIVE;
          end
        end
        default: begin
          state_d = S_DRIVE;
          if (res_kind == cand_kind_q && res_code == cand_code_q) begin
            stable_d = (stable_q == SC_MAX) ? stable_q : stable_q + SC_W'(1);
          end else begin
            cand_kind_d = res_kind;
            cand_code_d = res_code;
            stable_d    = SC_W'(1);
          end
          // Ghost patterns never commit; the committed key simply holds.
          if (stable_d == SC_MAX) begin
            if (cand_kind_d == R_NONE && key_held_q) begin
              key_held_d    = 1'b0;
              key_release_d = 1'b1;
            end else if (cand_kind_d == R_KEY &&
                         (!key_held_q || cand_code_d != key_code_q)) begin
              key_release_d = key_held_q;
              key_held_d    = 1'b1;
              key_code_d    = cand_code_d;
              key_valid_d   = 1'b1;
              if (key_valid_q && !kp.key_ready) begin
                overrun_d = 1'b1;
              end
            end
          end
        end
      endcase
    end else begin
      state_d     = S_IDLE;
      idx_d       = 2'd0;
      dwell_d     = '0;
      pat_d       = '1;
      cand_kind_d = R_NONE;
      cand_code_d = 4'd0;
      stable_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q    <= 4'hF;
      col_s_q       <= 4'hF;
      state_q       <= S_IDLE;
      idx_q         <= 2'd0;
      dwell_q       <= '0;
      pat_q         <= '1;
      cand_kind_q   <= R_NONE;
      cand_code_q   <= 4'd0;
      stable_q      <= '0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      col_meta_q    <= col_i;
      col_s_q       <= col_meta_q;
      state_q       <= state_d;
      idx_q         <= idx_d;
      dwell_q       <= dwell_d;
      pat_q         <= pat_d;
      cand_kind_q   <= cand_kind_d;
      cand_code_q   <= cand_code_d;
      stable_q      <= stable_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
      overrun_q     <= overrun_d;
    end
  end

  // The strobed row stays low through NEXT so each row is held ROW_DWELL+1 cycles.
  assign row_o = (state_q == S_DRIVE || state_q == S_NEXT) ?
                 ~(4'b0001 << idx_q) : 4'hF;

  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_held    = key_held_q;
  assign kp.key_release = key_release_q;
  assign kp.overrun     = overrun_q;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan sequencer and key-event controller for the 4x4 matrix keypad of the stopwatch-calculator. It strobes the rows with a fixed dwell and samples the synchronized columns once per row. It debounces over whole scans, rejects multi-key (ghost) patterns, and hands key press and release events to the calculator/stopwatch FSM over a valid/ready handshake.

Parameters:
ROW_DWELL, 12500, clk cycles each row is held low (250 us at 50 MHz); minimum 8
DEB_SCANS, 8, consecutive identical full-scan results required to commit a change; minimum 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scanning enabled
col  in  4  keypad columns, active-low, asynchronous (pulled up)
row  out  4  keypad rows, active-low, one-hot-low while scanning
key_code  out  4  committed key code
key_valid  out  1  press event pending
key_ready  in  1  consumer accepts the press event
key_held  out  1  a key is currently committed as pressed
key_release  out  1  one-cycle pulse when the committed key is released
overrun  out  1  sticky: press committed while key_valid still pending

Behaviour:
- Reset, asynchronous: row=4'b1111; key_code=0; key_valid=0; key_held=0; key_release=0; overrun=0; all counters, candidate and committed state cleared; FSM=IDLE.
- col passes through a 2-FF synchronizer (col_s) before any use.
- FSM states:
  - IDLE: row=1111. Go to DRIVE with row index 0 when enable=1.
  - DRIVE: row[idx]=0, others 1. Dwell counter runs 0..ROW_DWELL-1. On the last dwell cycle, sample col_s into the per-row pattern and go to NEXT.
  - NEXT: if idx<3, then idx+1 and DRIVE. If idx=3, then EVAL and idx=0.
  - EVAL: one cycle. Evaluate the scan result, update debounce, then DRIVE at row 0.
- Full scan length = 4*(ROW_DWELL+1)+1 cycles.
- Code map, (row,col) with col0..3:
  - r0 = 1, 2, 3, A(10)
  - r1 = 4, 5, 6, B(11)
  - r2 = 7, 8, 9, C(12)
  - r3 = star(15), 0, hashtag(14), D(13)
- Scan result:
  - NONE: no low bit in any row.
  - KEY(code): exactly one low bit in the whole matrix.
  - MULTI: two or more low bits.
- Debounce, in EVAL:
  - If the result equals the candidate: stable_cnt++, saturating at DEB_SCANS.
  - Otherwise: candidate=result, stable_cnt=1.
  - Commit when stable_cnt reaches DEB_SCANS and the candidate differs from the committed state. MULTI is never committed; the committed state holds.
- Commit actions, registered on the cycle after EVAL:
  - NONE->KEY(c): key_code=c, key_held=1. If key_valid=1 already, set overrun=1 and replace key_code anyway. key_valid=1.
  - KEY(c)->NONE: key_held=0, key_release=1 for one cycle. key_code is retained.
  - KEY(a)->KEY(b): key_release pulse and a press of b in the same cycle (press rules as above).
- Handshake:
  - key_valid stays high until a cycle with key_valid&key_ready, then clears next cycle.
  - A simultaneous ready and new commit gives key_valid=1 with the new code and no overrun.
  - key_code is stable while key_valid=1, except on overrun.
- overrun: cleared only by reset.
- enable deasserted mid-scan:
  - Next cycle row=1111 and FSM=IDLE.
  - Dwell counter, idx, row patterns, candidate and stable_cnt are cleared.
  - Committed state, key_held, key_valid and overrun are kept.
  - Re-enable restarts at row 0 with a fresh debounce.
- Press latency from stable contact: between DEB_SCANS and DEB_SCANS+1 full scans, plus 3 cycles.

Test Plan (ROW_DWELL=8, DEB_SCANS=3, scan=37 cycles):
- Reset, enable=1, no key -> row cycles 1110,1101,1011,0111 with 9 cycles each; key_valid=0, key_release=0 throughout.
- Hold key 5 (col1 low only while row1 low), key_ready=0 -> key_valid=1 and key_code=5 within 4 scans; key_held=1; stays 1 until key_ready=1, then drops the next cycle.
- Key 9 bouncing (alternating pattern every other scan) for 5 scans, then stable -> no event during the bounce; key_code=9 only after 3 consecutive stable scans.
- Hold 1 and 6 together -> MULTI, no key_valid. Release 6 keeping 1 -> key_code=1 after 3 scans.
- Press star and accept it, release, then press hashtag without key_ready -> key_release pulse at 1 cycle; key_code=14, key_valid=1. Press D before ready -> key_code=13, overrun=1.
- Hold 0, drop enable mid-row2 -> row=1111 next cycle, key_held unchanged. Assert rst_n=0 mid-scan -> all outputs at reset values immediately.
